// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the core, ext and memory buses of the data-memory arbiter
//   slave  : arbiter side (takes requests and mem_rdata, drives acks/rdata/memory controls)
//   master : environment side (pipeline, loader and memory model)
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_ack;
  logic          core_stall;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;
  logic          ext_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack, core_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack, core_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core memory stage and an ext loader port
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : core request/ack/stall, ext request/done and memory controls (dmem_arbiter_if.slave)
module dmem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rstn,
  dmem_arbiter_if.slave bus
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, CORE_ACC, EXT_ACC} state_t;
  state_t        state, nextState;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic          latWe;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latWdata;
  logic          busy, lastBeat, extWin, grant;
  always_comb begin
    busy            = state != IDLE;
    lastBeat        = busy && cnt == LAST;
    extWin          = bus.ext_req && (starve == SMAX || !bus.core_req);
    nextState       = !busy ? (extWin ? EXT_ACC : (bus.core_req ? CORE_ACC : IDLE))
                            : (lastBeat ? IDLE : state);
    grant           = !busy && nextState != IDLE;
    bus.mem_en      = busy;
    bus.mem_we      = busy && latWe;
    bus.mem_addr    = latAddr;
    bus.mem_wdata   = latWdata;
    bus.core_ack    = state == CORE_ACC && lastBeat;
    bus.ext_done    = state == EXT_ACC && lastBeat;
    bus.core_rdata  = bus.core_ack ? bus.mem_rdata : '0;
    bus.ext_rdata   = bus.ext_done ? bus.mem_rdata : '0;
    // gated by rstn so the stall drops the moment reset asserts
    bus.core_stall  = rstn && bus.core_req && !bus.core_ack;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else begin
      state  <= nextState;
      cnt    <= grant ? '0 : (busy ? cnt + 1'b1 : cnt);
      starve <= (grant && extWin) ? '0
              : (bus.ext_req && state != EXT_ACC && starve != SMAX) ? starve + 1'b1 : starve;
      if (grant) begin
        latWe    <= extWin ? bus.ext_we    : bus.core_we;
        latAddr  <= extWin ? bus.ext_addr  : bus.core_addr;
        latWdata <= extWin ? bus.ext_wdata : bus.core_wdata;
      end
    end
  end
endmodule
